// File: rtl/stream_conv_pkg.sv
`default_nettype none
// ============================================================================
// stream_conv_pkg
//   Shared widths and sizing helpers for the streaming convolution engine.
//   Rev 1.0 - initial release
// ============================================================================
package stream_conv_pkg;

    localparam int RESULT_SCALE = 2;   // results and products are RESULT_SCALE*N bits
    localparam int MSIZE_W      = 14;
    localparam int STRIDE_W     = 6;

    // Width of a counter spanning every pixel of the largest map.
    function automatic int pix_cnt_w(input int max_m);
        int v;
        v = max_m * max_m;
        return (v > 1) ? $clog2(v) : 1;
    endfunction

    // Width of the delay-line tap selector, which ranges over 0..MaxMatrixSize-K.
    function automatic int dly_sel_w(input int max_m, input int k);
        int v;
        v = max_m - k + 1;
        return (v > 1) ? $clog2(v) : 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/conv_mac.sv
`default_nettype none
// ============================================================================
// conv_mac
//   Registered signed multiply-add tap: mac_o <= value*mult + add when enabled.
//   Rev 1.0 - initial release
// ============================================================================
module conv_mac
    import stream_conv_pkg::*;
#(
    parameter int N = 16
) (
    input  logic                             clk_i,
    input  logic                             rst_ni,
    input  logic                             en_i,
    input  logic signed [N-1:0]              value_i,
    input  logic signed [N-1:0]              mult_i,
    input  logic signed [RESULT_SCALE*N-1:0] add_i,
    output logic signed [RESULT_SCALE*N-1:0] mac_o
);

    localparam int c_RW = RESULT_SCALE * N;

    logic signed [c_RW-1:0] w_value;
    logic signed [c_RW-1:0] w_mult;
    logic signed [c_RW-1:0] w_prod;
    logic signed [c_RW-1:0] r_mac;

    // Sign-extend first; the low c_RW bits of the wide product are the exact N x N result.
    assign w_value = $signed({{(c_RW-N){value_i[N-1]}}, value_i});
    assign w_mult  = $signed({{(c_RW-N){mult_i[N-1]}}, mult_i});
    assign w_prod  = w_value * w_mult;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_mac <= '0;
        end else if (en_i) begin
            r_mac <= w_prod + add_i;
        end
    end

    assign mac_o = r_mac;

endmodule
`default_nettype wire

// File: rtl/stream_convolver.sv
`default_nettype none
// ============================================================================
// stream_convolver
//   Streaming KxK signed correlation over a raster-order square map using a
//   transposed MAC tap chain with row delay lines; strided valid windows.
//   Optional: define STREAM_CONVOLVER_ASSERT_EN for geometry assertions.
//   Rev 1.0 - initial release
// ============================================================================
module stream_convolver
    import stream_conv_pkg::*;
#(
    parameter int MaxMatrixSize = 10,
    parameter int KernelSize    = 3,
    parameter int N             = 16
) (
    input  logic                             clk_i,
    input  logic                             rst_ni,
    input  logic                             en_i,
    input  logic signed [N-1:0]              data_i,
    input  logic        [STRIDE_W-1:0]       stride_i,
    input  logic        [MSIZE_W-1:0]        matrix_size_i,
    input  logic signed [N-1:0]              weights_i [KernelSize*KernelSize],
    output logic signed [RESULT_SCALE*N-1:0] conv_o,
    output logic                             valid_conv_o,
    output logic                             end_conv_o
);

    localparam int c_TAPS  = KernelSize * KernelSize;
    localparam int c_RW    = RESULT_SCALE * N;
    localparam int c_DEPTH = MaxMatrixSize - KernelSize;
    localparam int c_SW    = dly_sel_w(MaxMatrixSize, KernelSize);
    localparam logic [MSIZE_W-1:0] c_KM1 = MSIZE_W'(KernelSize - 1);
    localparam logic [MSIZE_W-1:0] c_K   = MSIZE_W'(KernelSize);

    logic                   r_started;
    logic [MSIZE_W-1:0]     r_msize;
    logic [STRIDE_W-1:0]    r_stride;
    logic [MSIZE_W-1:0]     r_row;
    logic [MSIZE_W-1:0]     r_col;
    logic [STRIDE_W-1:0]    r_row_ph;
    logic [STRIDE_W-1:0]    r_col_ph;
    logic                   r_valid;
    logic                   r_end;

    logic                   w_acc;
    logic [MSIZE_W-1:0]     w_msize;
    logic [STRIDE_W-1:0]    w_stride;
    logic [STRIDE_W-1:0]    w_stride_m1;
    logic                   w_last_col;
    logic                   w_last_row;
    logic                   w_row_in;
    logic                   w_col_in;
    logic                   w_win;
    logic [c_SW-1:0]        w_dsel;

    logic signed [c_RW-1:0] w_tap_in  [c_TAPS];
    logic signed [c_RW-1:0] w_tap_out [c_TAPS];
    logic signed [c_RW-1:0] w_dly_out [KernelSize-1];

    assign w_acc = en_i & ~r_end;

    // Geometry is live on the very first beat, then frozen until reset.
    assign w_msize     = r_started ? r_msize : matrix_size_i;
    assign w_stride    = r_started ? r_stride
                                   : ((stride_i == '0) ? STRIDE_W'(1) : stride_i);
    assign w_stride_m1 = w_stride - STRIDE_W'(1);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_started <= 1'b0;
            r_msize   <= '0;
            r_stride  <= '0;
        end else if (w_acc && !r_started) begin
            r_started <= 1'b1;
            r_msize   <= w_msize;
            r_stride  <= w_stride;
        end
    end

    assign w_last_col = (r_col == w_msize - MSIZE_W'(1));
    assign w_last_row = (r_row == w_msize - MSIZE_W'(1));
    assign w_row_in   = (r_row >= c_KM1);
    assign w_col_in   = (r_col >= c_KM1);
    // Phases sit at zero until the window's bottom-right corner enters the map.
    assign w_win      = w_row_in & w_col_in & (r_row_ph == '0) & (r_col_ph == '0);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_row    <= '0;
            r_col    <= '0;
            r_row_ph <= '0;
            r_col_ph <= '0;
            r_valid  <= 1'b0;
            r_end    <= 1'b0;
        end else begin
            r_valid <= w_acc & w_win;
            if (w_acc) begin
                if (w_last_row && w_last_col) begin
                    r_end <= 1'b1;
                end
                if (w_last_col) begin
                    r_col    <= '0;
                    r_col_ph <= '0;
                    r_row    <= r_row + MSIZE_W'(1);
                    if (!w_row_in || (r_row_ph == w_stride_m1)) begin
                        r_row_ph <= '0;
                    end else begin
                        r_row_ph <= r_row_ph + STRIDE_W'(1);
                    end
                end else begin
                    r_col <= r_col + MSIZE_W'(1);
                    if (!w_col_in || (r_col_ph == w_stride_m1)) begin
                        r_col_ph <= '0;
                    end else begin
                        r_col_ph <= r_col_ph + STRIDE_W'(1);
                    end
                end
            end
        end
    end

    // Tap k = r*K + c; every tap sees the live pixel, partial sums ripple forward.
    for (genvar k = 0; k < c_TAPS; k++) begin : g_tap
        if (k == 0) begin : g_head
            assign w_tap_in[k] = '0;
        end else if ((k % KernelSize) == 0) begin : g_row_start
            assign w_tap_in[k] = w_dly_out[(k / KernelSize) - 1];
        end else begin : g_inner
            assign w_tap_in[k] = w_tap_out[k-1];
        end

        conv_mac #(
            .N (N)
        ) u_mac (
            .clk_i   (clk_i),
            .rst_ni  (rst_ni),
            .en_i    (w_acc),
            .value_i (data_i),
            .mult_i  (weights_i[k]),
            .add_i   (w_tap_in[k]),
            .mac_o   (w_tap_out[k])
        );
    end

    assign w_dsel = c_SW'(w_msize - c_K);

    // Row hand-off delays M-K beats on top of the tap register, skipping the rest of the row.
    for (genvar r = 0; r < KernelSize - 1; r++) begin : g_row_dly
        if (c_DEPTH > 0) begin : g_line
            logic signed [c_RW-1:0] r_line [c_DEPTH];
            logic signed [c_RW-1:0] w_sel;

            always_ff @(posedge clk_i or negedge rst_ni) begin
                if (!rst_ni) begin
                    for (int i = 0; i < c_DEPTH; i++) begin
                        r_line[i] <= '0;
                    end
                end else if (w_acc) begin
                    r_line[0] <= w_tap_out[r*KernelSize + KernelSize - 1];
                    for (int i = 1; i < c_DEPTH; i++) begin
                        r_line[i] <= r_line[i-1];
                    end
                end
            end

            always_comb begin
                w_sel = w_tap_out[r*KernelSize + KernelSize - 1];
                for (int i = 0; i < c_DEPTH; i++) begin
                    if (w_dsel == c_SW'(i + 1)) begin
                        w_sel = r_line[i];
                    end
                end
            end

            assign w_dly_out[r] = w_sel;
        end else begin : g_direct
            assign w_dly_out[r] = w_tap_out[r*KernelSize + KernelSize - 1];
        end
    end

    assign conv_o       = w_tap_out[c_TAPS-1];
    assign valid_conv_o = r_valid;
    assign end_conv_o   = r_end;

`ifdef STREAM_CONVOLVER_ASSERT_EN
    a_geometry : assert property (@(posedge clk_i) disable iff (!rst_ni)
        w_acc |-> ((KernelSize > 1) && (N > 0)
                   && (matrix_size_i >= c_K)
                   && (matrix_size_i <= MSIZE_W'(MaxMatrixSize))
                   && ({{(MSIZE_W-STRIDE_W){1'b0}}, stride_i} < matrix_size_i)))
        else $error("stream_convolver: illegal geometry M=%0d S=%0d",
                    matrix_size_i, stride_i);
`else
    // Unchecked build: out-of-range geometry still wraps in the datapath and never stalls.
`endif

endmodule
`default_nettype wire

// File: tb/tb_stream_convolver.sv
`default_nettype none
// ============================================================================
// tb_stream_convolver
//   Directed bench: 8x8 ramp map (stride 1/2, gapped), 5x5 all-ones map,
//   mid-map reset, and beats after end-of-map.
//   Rev 1.0 - initial release
// ============================================================================
module tb_stream_convolver;

    localparam int c_MAXM = 10;
    localparam int c_K    = 3;
    localparam int c_N    = 16;
    localparam int c_TAPS = c_K * c_K;

    logic                  clk_i = 1'b0;
    logic                  rst_ni;
    logic                  en_i;
    logic signed [15:0]    data_i;
    logic        [5:0]     stride_i;
    logic        [13:0]    matrix_size_i;
    logic signed [15:0]    weights_i [c_TAPS];
    logic signed [31:0]    conv_o;
    logic                  valid_conv_o;
    logic                  end_conv_o;

    int          n_checks = 0;
    int          n_pass   = 0;
    logic [31:0] got_q [$];
    int          first_valid;
    int          end_at;
    int          gap_valids;
    logic [31:0] hold;
    int          exp_s2 [9] = '{474, 546, 618, 1050, 1122, 1194, 1626, 1698, 1770};

    stream_convolver #(
        .MaxMatrixSize (c_MAXM),
        .KernelSize    (c_K),
        .N             (c_N)
    ) u_dut (
        .clk_i         (clk_i),
        .rst_ni        (rst_ni),
        .en_i          (en_i),
        .data_i        (data_i),
        .stride_i      (stride_i),
        .matrix_size_i (matrix_size_i),
        .weights_i     (weights_i),
        .conv_o        (conv_o),
        .valid_conv_o  (valid_conv_o),
        .end_conv_o    (end_conv_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic beat_step(input logic en, input logic signed [15:0] d, input int pix);
        en_i   = en;
        data_i = d;
        tick();
        if (valid_conv_o) begin
            if (!en) gap_valids++;
            else begin
                got_q.push_back(conv_o);
                if (first_valid < 0) first_valid = pix;
            end
        end
        if (end_conv_o && end_at < 0) end_at = pix;
    endtask

    // Streams pixels 0..last; geometry inputs are scrambled after the first beat.
    task automatic run_map(input int m, input int s, input int last, input bit gaps, input bit ones);
        got_q.delete();
        first_valid   = -1;
        end_at        = -1;
        gap_valids    = 0;
        matrix_size_i = 14'(m);
        stride_i      = 6'(s);
        for (int p = 0; p < m * m && p <= last; p++) begin
            if (gaps && p > 0 && (p % 10) == 0)
                for (int g = 0; g < 3; g++) beat_step(1'b0, 16'sh7777, p);
            beat_step(1'b1, ones ? 16'sd1 : 16'(p), p);
            if (p == 0) begin
                matrix_size_i = 14'd9;
                stride_i      = 6'd3;
            end
        end
        en_i = 1'b0;
    endtask

    // Ramp map with weights[k]=k: window (R,C) = 474 + 36*C + 288*R.
    task automatic check_ramp(input string tag, input int s);
        int n;
        n = 0;
        for (int r = 0; r <= 5; r += s)
            for (int c = 0; c <= 5; c += s) begin
                check($sformatf("%s_v%0d", tag, n),
                      (n < got_q.size()) ? got_q[n] : 32'hDEADBEEF,
                      32'(474 + 36 * c + 288 * r));
                n++;
            end
        check($sformatf("%s_count", tag), 32'(got_q.size()), 32'(n));
    endtask

    task automatic do_reset();
        en_i   = 1'b0;
        rst_ni = 1'b0;
        tick();
        tick();
        rst_ni = 1'b1;
        tick();
    endtask

    initial begin
        rst_ni        = 1'b0;
        en_i          = 1'b0;
        data_i        = '0;
        stride_i      = 6'd1;
        matrix_size_i = 14'd8;
        for (int k = 0; k < c_TAPS; k++) weights_i[k] = 16'(k);
        repeat (3) tick();
        check("rst_conv",  conv_o, 32'd0);
        check("rst_valid", 32'(valid_conv_o), 32'd0);
        check("rst_end",   32'(end_conv_o), 32'd0);
        rst_ni = 1'b1;
        tick();

        // 8x8 ramp, stride 1
        run_map(8, 1, 63, 1'b0, 1'b0);
        check_ramp("s1", 1);
        check("s1_first_valid", 32'(first_valid), 32'd18);
        check("s1_end_at", 32'(end_at), 32'd63);

        // Beats after end of map are ignored
        hold = conv_o;
        got_q.delete();
        for (int i = 0; i < 4; i++) beat_step(1'b1, 16'sd500, 64 + i);
        check("post_valids", 32'(got_q.size()), 32'd0);
        check("post_conv", conv_o, hold);
        check("post_end", 32'(end_conv_o), 32'd1);

        // Stride 2
        do_reset();
        run_map(8, 2, 63, 1'b0, 1'b0);
        for (int i = 0; i < 9; i++)
            check($sformatf("s2_v%0d", i), (i < got_q.size()) ? got_q[i] : 32'hDEADBEEF, 32'(exp_s2[i]));
        check("s2_count", 32'(got_q.size()), 32'd9);
        check("s2_end_at", 32'(end_at), 32'd63);

        // Enable gaps: 3 idle cycles every 10 beats
        do_reset();
        run_map(8, 1, 63, 1'b1, 1'b0);
        check_ramp("gap", 1);
        check("gap_idle_valids", 32'(gap_valids), 32'd0);
        check("gap_first_valid", 32'(first_valid), 32'd18);

        // 5x5 all-ones map, weights all -1
        do_reset();
        for (int k = 0; k < c_TAPS; k++) weights_i[k] = -16'sd1;
        run_map(5, 1, 24, 1'b0, 1'b1);
        for (int i = 0; i < 9; i++)
            check($sformatf("m5_v%0d", i), (i < got_q.size()) ? got_q[i] : 32'hDEADBEEF, 32'hFFFFFFF7);
        check("m5_count", 32'(got_q.size()), 32'd9);
        check("m5_end_at", 32'(end_at), 32'd24);
        for (int k = 0; k < c_TAPS; k++) weights_i[k] = 16'(k);

        // Reset mid-map, then a fresh stride-1 map
        do_reset();
        run_map(8, 2, 30, 1'b0, 1'b0);
        rst_ni = 1'b0;
        #1;
        check("mid_rst_conv",  conv_o, 32'd0);
        check("mid_rst_valid", 32'(valid_conv_o), 32'd0);
        check("mid_rst_end",   32'(end_conv_o), 32'd0);
        tick();
        rst_ni = 1'b1;
        tick();
        run_map(8, 1, 63, 1'b0, 1'b0);
        check_ramp("rr", 1);
        check("rr_end_at", 32'(end_at), 32'd63);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
